// File: rtl/field_multiplier.sv
// rtl/field_multiplier.sv - digit-serial full-width multiplier feeding the Barrett reducer

package elliptic_curve_structs;
  localparam int P_WIDTH = 256;

  typedef struct packed {
    logic [P_WIDTH-1:0] p;
  } curve_params_t;

  localparam curve_params_t params = '{
    p: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
  };
endpackage

module field_multiplier
  import elliptic_curve_structs::*;
#(
  parameter int DIGIT_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [P_WIDTH-1:0]     a,
  input  logic [P_WIDTH-1:0]     b,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*P_WIDTH-1:0]   product
);

  localparam int NDIG  = (P_WIDTH + DIGIT_W - 1) / DIGIT_W;
  localparam int EXT_W = NDIG * DIGIT_W;
  localparam int ACC_W = 2 * P_WIDTH + DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } state_t;

  state_t             state_q;
  logic [EXT_W-1:0]   a_q;
  logic [EXT_W-1:0]   b_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               out_valid_q;
  logic [DIGIT_W-1:0] digit;
  logic [ACC_W-1:0]   partial;

  // One digit of b per MUL cycle, weighted by its position in b.
  always_comb begin
    digit   = b_q[cnt_q * DIGIT_W +: DIGIT_W];
    partial = ACC_W'(a_q) * ACC_W'(digit);
    acc_d   = acc_q + (partial << (cnt_q * DIGIT_W));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= EXT_W'(a);
            b_q     <= EXT_W'(b);
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NDIG - 1)) begin
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          // A start coinciding with the handoff is left for the next IDLE cycle.
          if (out_ready) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign product   = acc_q[2*P_WIDTH-1:0];

  // Headroom bits above the product can never be reached by operands below 2^P_WIDTH.
  assert property (@(posedge clk) disable iff (!reset) acc_q[ACC_W-1:2*P_WIDTH] == '0);

endmodule

// File: tb/tb_field_multiplier.sv
// tb/tb_field_multiplier.sv - scoreboard bench for field_multiplier against a plain a*b model

module tb_field_multiplier;
  import elliptic_curve_structs::*;

  localparam int DIGIT_W = 64;
  localparam int NDIG    = (P_WIDTH + DIGIT_W - 1) / DIGIT_W;
  localparam int PW2     = 2 * P_WIDTH;

  typedef logic [P_WIDTH-1:0] op_t;
  typedef logic [PW2-1:0]     prod_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  start;
  logic  out_ready;
  logic  busy;
  logic  out_valid;
  op_t   a;
  op_t   b;
  prod_t product;

  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  prod_t exp_q[$];
  int    start_q[$];

  field_multiplier #(.DIGIT_W(DIGIT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic prod_t ref_mul(op_t x, op_t y);
    return prod_t'(x) * prod_t'(y);
  endfunction

  function automatic op_t rand_op();
    op_t v;
    for (int i = 0; i < P_WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_prod(string name, prod_t act, prod_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic check_int(string name, int act, int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each handoff.
  logic  pv = 1'b0;
  logic  pr = 1'b0;
  prod_t pp = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && !pv) begin
        if (start_q.size() == 0) begin
          check_int("unexpected_valid", 1, 0);
        end else begin
          check_int("latency", cyc - start_q.pop_front(), NDIG);
        end
      end
      if (pv && pr) check_int("valid_one_cycle", int'(out_valid), 0);
      if (pv && !pr) begin
        check_int("hold_valid", int'(out_valid), 1);
        check_prod("hold_product", product, pp);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_int("unexpected_handoff", 1, 0);
        else check_prod("product", product, exp_q.pop_front());
      end
    end
    pv = out_valid;
    pr = out_ready;
    pp = product;
  end

  // Called one step after a rising edge with the DUT idle.
  task automatic issue(op_t x, op_t y, prod_t expv);
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start_q.push_back(cyc);
    start = 1'b0;
  endtask

  task automatic wait_drain(int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      check_int("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      start_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t x, y, pm1;
    pm1       = params.p - op_t'(1);
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #3;
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_valid", int'(out_valid), 0);
    check_prod("reset_product", product, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    issue(op_t'(123), op_t'(456), prod_t'(56088));
    wait_drain(20);

    for (int j = 0; j < 6; j++) begin
      x = rand_op();
      y = rand_op();
      issue(x, y, ref_mul(x, y));
      wait_drain(20);
    end

    issue(pm1, pm1, ref_mul(pm1, pm1));
    wait_drain(20);

    // Stalled handoff with start and fresh operands arriving during HOLD.
    out_ready = 1'b0;
    issue('0, pm1, '0);
    repeat (NDIG) begin
      @(posedge clk);
      #1;
    end
    check_int("hold_reached", int'(out_valid), 1);
    repeat (5) begin
      start = 1'b1;
      a     = rand_op();
      b     = rand_op();
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    wait_drain(20);
    check_int("ignored_start_busy", int'(busy), 0);

    // Start coinciding with the handoff must wait for IDLE.
    out_ready = 1'b0;
    x = rand_op();
    y = rand_op();
    issue(x, y, ref_mul(x, y));
    repeat (NDIG) begin
      @(posedge clk);
      #1;
    end
    x = rand_op();
    y = rand_op();
    a         = x;
    b         = y;
    start     = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(ref_mul(x, y));
    @(posedge clk);
    #1;
    check_int("handoff_no_restart", int'(busy), 0);
    @(posedge clk);
    #1;
    start_q.push_back(cyc);
    start = 1'b0;
    wait_drain(20);

    // Back-to-back with start held; operands churn while busy.
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      x     = rand_op();
      y     = rand_op();
      a     = x;
      b     = y;
      start = 1'b1;
      exp_q.push_back(ref_mul(x, y));
      @(posedge clk);
      #1;
      start_q.push_back(cyc);
      if (j < 5) begin
        for (int k = 0; k < NDIG + 1; k++) begin
          a = rand_op();
          b = rand_op();
          @(posedge clk);
          #1;
        end
      end else begin
        start = 1'b0;
      end
    end
    wait_drain(40);

    // Abort in the middle of MUL.
    a     = rand_op();
    b     = rand_op();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_valid", int'(out_valid), 0);
    check_prod("abort_product", product, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    issue(op_t'(2), op_t'(3), prod_t'(6));
    wait_drain(20);
    repeat (NDIG + 2) @(posedge clk);
    #1;

    check_int("queues_empty", exp_q.size() + start_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
